// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war match sequencer and the playfield winner encoding.
package tug_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        PLAY  = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;

    // Exactly one side flagged; 11 from the playfield is treated as no result.
    function automatic logic is_win(input logic [1:0] w);
        return (w == WIN_LEFT) || (w == WIN_RIGHT);
    endfunction

endpackage

// File: rtl/tug_match_ctrl_score_counter.sv
// Saturating 3-bit round-win counter with synchronous clear.
module score_counter #(
    parameter int MAX = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [2:0] count
);

    localparam logic [2:0] MAX3 = 3'(MAX);

    always_ff @(posedge clk) begin
        if (reset)
            count <= 3'd0;
        else if (inc && count != MAX3)
            count <= count + 3'd1;
    end

endmodule

// File: rtl/tug_match_ctrl.sv
// Best-of-N match sequencer: gates presses into the playfield, scores rounds,
// freezes each result for HOLD_CYCLES, then re-arms or declares the match.
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L_in,
    input  logic       R_in,
    input  logic [1:0] winner,
    output logic       pf_reset,
    output logic       pf_L,
    output logic       pf_R,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic       match_over,
    output logic [1:0] match_winner
);

    localparam int          CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0]  WIN3      = 3'(WIN_SCORE);

    state_t          state;
    logic [CW-1:0]   hold_cnt;
    logic [1:0]      inc;
    logic [1:0][2:0] score;
    logic            in_play;

    assign in_play  = (state == PLAY) && !reset;
    assign pf_reset = reset || (state == CLEAR);
    assign pf_L     = in_play && L_in;
    assign pf_R     = in_play && R_in;

    // Side index follows the winner code bit: [1] = left, [0] = right.
    for (genvar s = 0; s < 2; s++) begin : g_side
        assign inc[s] = in_play && is_win(winner) && winner[s];
        score_counter #(.MAX(WIN_SCORE)) u_score (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[s]),
            .count (score[s])
        );
    end

    assign score_l = score[1];
    assign score_r = score[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            hold_cnt     <= '0;
            match_over   <= 1'b0;
            match_winner <= WIN_NONE;
        end else begin
            case (state)
                CLEAR: state <= PLAY;
                PLAY: begin
                    if (is_win(winner)) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    // Scores already reflect the round just won by the time we exit.
                    if (hold_cnt == HOLD_LAST) begin
                        if (score_l == WIN3 || score_r == WIN3) begin
                            state        <= DONE;
                            match_over   <= 1'b1;
                            match_winner <= (score_l == WIN3) ? WIN_LEFT : WIN_RIGHT;
                        end else begin
                            state <= CLEAR;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                DONE:    state <= DONE;
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
